// File: rtl/pportmux.sv
// pportmux: two-requester multiplexer/sequencer for the 7-bit parallel-port
// byte stream. TX shares one channel between requesters A and B by inserting
// in-band channel-select (SEL_A/SEL_B) and escape (ESC) codes; RX strips those
// codes and steers payload bytes to the addressed requester.
// Optional feature macro: PPMUX_RXDEMUX_EN (RX code interpretation). When it
// is undefined, RX is a plain one-cycle registered pass-through to A.
module pportmux #(
    parameter int LGBURST = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_a_stb,
    input  logic [6:0] i_a_data,
    output logic       o_a_busy,
    input  logic       i_b_stb,
    input  logic [6:0] i_b_data,
    output logic       o_b_busy,
    output logic       o_pp_stb,
    output logic [6:0] o_pp_data,
    input  logic       i_pp_busy,
    input  logic       i_pp_stb,
    input  logic [6:0] i_pp_data,
    output logic       o_a_rx_stb,
    output logic       o_b_rx_stb,
    output logic [6:0] o_rx_data
);

    localparam logic [6:0] CODE_ESC   = 7'h7d;
    localparam logic [6:0] CODE_SEL_A = 7'h7e;
    localparam logic [6:0] CODE_SEL_B = 7'h7f;
    localparam logic [6:0] CODE_XOR   = 7'h20;

    // Burst limit 2^LGBURST, saturation value and increment in counter width.
    localparam logic [LGBURST:0] BURST_LIM = {1'b1, {LGBURST{1'b0}}};
    localparam logic [LGBURST:0] BURST_SAT = {(LGBURST+1){1'b1}};
    localparam logic [LGBURST:0] BURST_ONE = {{LGBURST{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_ESC  = 2'd2,
        ST_DATA = 2'd3
    } tx_state_t;

    // A byte collides with an in-band code and must be escaped on the wire.
    function automatic logic is_reserved(input logic [6:0] b);
        return (b >= CODE_ESC);
    endfunction

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    tx_state_t        state_q, state_d;
    logic             owner_q, owner_d;          // 0 = A, 1 = B
    logic             sel_valid_q, sel_valid_d;  // a SEL has been sent since reset
    logic [LGBURST:0] burst_cnt_q, burst_cnt_d;
    logic             gnt_q, gnt_d;              // requester of the latched byte
    logic [6:0]       byte_q, byte_d;
    logic             esc_q, esc_d;              // latched byte needs escaping
    logic             pp_stb_q, pp_stb_d;
    logic [6:0]       pp_data_q, pp_data_d;

    logic             own_req;
    logic             oth_req;
    logic             grant_valid;
    logic             grant_b;
    logic             burst_clr;
    logic [6:0]       grant_byte;
    logic             accept;
    logic             pp_consume;

    // Arbiter: pick the requester served in IDLE (owner keeps a burst, then yields).
    always_comb begin
        own_req     = owner_q ? i_b_stb : i_a_stb;
        oth_req     = owner_q ? i_a_stb : i_b_stb;
        grant_valid = 1'b0;
        grant_b     = owner_q;
        burst_clr   = 1'b0;
        if (own_req && (burst_cnt_q < BURST_LIM)) begin
            grant_valid = 1'b1;
            grant_b     = owner_q;
        end else if (oth_req) begin
            grant_valid = 1'b1;
            grant_b     = ~owner_q;
        end else if (own_req) begin
            // Owner exhausted its burst but nobody else wants the channel.
            grant_valid = 1'b1;
            grant_b     = owner_q;
            burst_clr   = 1'b1;
        end else begin
            grant_valid = 1'b0;
            grant_b     = owner_q;
        end
    end

    assign grant_byte = grant_b ? i_b_data : i_a_data;
    assign accept     = !i_rst && (state_q == ST_IDLE) && grant_valid;
    assign pp_consume = pp_stb_q && !i_pp_busy;

    // Only the granted requester sees busy low, and only in IDLE outside reset.
    assign o_a_busy = i_rst || (state_q != ST_IDLE) || !(grant_valid && !grant_b);
    assign o_b_busy = i_rst || (state_q != ST_IDLE) || !(grant_valid &&  grant_b);

    // TX sequencer: latch accepted byte, then emit SEL / ESC / DATA as needed.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        sel_valid_d = sel_valid_q;
        burst_cnt_d = burst_cnt_q;
        gnt_d       = gnt_q;
        byte_d      = byte_q;
        esc_d       = esc_q;
        pp_stb_d    = pp_stb_q;
        pp_data_d   = pp_data_q;
        case (state_q)
            ST_IDLE: begin
                pp_stb_d = 1'b0;
                if (accept) begin
                    byte_d   = grant_byte;
                    esc_d    = is_reserved(grant_byte);
                    gnt_d    = grant_b;
                    pp_stb_d = 1'b1;
                    // The accepted byte itself is the first of a new run.
                    if ((grant_b != owner_q) || burst_clr) begin
                        burst_cnt_d = BURST_ONE;
                    end else if (burst_cnt_q == BURST_SAT) begin
                        burst_cnt_d = burst_cnt_q;
                    end else begin
                        burst_cnt_d = burst_cnt_q + BURST_ONE;
                    end
                    if ((grant_b != owner_q) || !sel_valid_q) begin
                        state_d   = ST_SEL;
                        pp_data_d = grant_b ? CODE_SEL_B : CODE_SEL_A;
                    end else if (is_reserved(grant_byte)) begin
                        state_d   = ST_ESC;
                        pp_data_d = CODE_ESC;
                    end else begin
                        state_d   = ST_DATA;
                        pp_data_d = grant_byte;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEL: begin
                if (pp_consume) begin
                    owner_d     = gnt_q;
                    sel_valid_d = 1'b1;
                    if (esc_q) begin
                        state_d   = ST_ESC;
                        pp_data_d = CODE_ESC;
                    end else begin
                        state_d   = ST_DATA;
                        pp_data_d = byte_q;
                    end
                end else begin
                    state_d = ST_SEL;
                end
            end
            ST_ESC: begin
                if (pp_consume) begin
                    state_d   = ST_DATA;
                    pp_data_d = byte_q ^ CODE_XOR;
                end else begin
                    state_d = ST_ESC;
                end
            end
            ST_DATA: begin
                if (pp_consume) begin
                    state_d  = ST_IDLE;
                    pp_stb_d = 1'b0;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                pp_stb_d = 1'b0;
            end
        endcase
    end

    // TX state registers; reset drops any latched byte and forgets the owner.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            sel_valid_q <= 1'b0;
            burst_cnt_q <= '0;
            gnt_q       <= 1'b0;
            byte_q      <= 7'h00;
            esc_q       <= 1'b0;
            pp_stb_q    <= 1'b0;
            pp_data_q   <= 7'h00;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            sel_valid_q <= sel_valid_d;
            burst_cnt_q <= burst_cnt_d;
            gnt_q       <= gnt_d;
            byte_q      <= byte_d;
            esc_q       <= esc_d;
            pp_stb_q    <= pp_stb_d;
            pp_data_q   <= pp_data_d;
        end
    end

    assign o_pp_stb  = pp_stb_q;
    assign o_pp_data = pp_data_q;

    // ------------------------------------------------------------------
    // RX path (independent of TX)
    // ------------------------------------------------------------------
    logic       rx_a_stb_q, rx_a_stb_d;
    logic       rx_b_stb_q, rx_b_stb_d;
    logic [6:0] rx_data_q, rx_data_d;

`ifdef PPMUX_RXDEMUX_EN
    logic       rx_sel_q, rx_sel_d;   // 0 = A, 1 = B
    logic       rx_esc_q, rx_esc_d;

    // RX demux: consume in-band codes, deliver payload to the selected requester.
    always_comb begin
        rx_sel_d   = rx_sel_q;
        rx_esc_d   = rx_esc_q;
        rx_a_stb_d = 1'b0;
        rx_b_stb_d = 1'b0;
        rx_data_d  = rx_data_q;
        if (i_pp_stb) begin
            if (rx_esc_q) begin
                rx_esc_d   = 1'b0;
                rx_a_stb_d = !rx_sel_q;
                rx_b_stb_d = rx_sel_q;
                rx_data_d  = i_pp_data ^ CODE_XOR;
            end else begin
                case (i_pp_data)
                    CODE_SEL_A: rx_sel_d = 1'b0;
                    CODE_SEL_B: rx_sel_d = 1'b1;
                    CODE_ESC:   rx_esc_d = 1'b1;
                    default: begin
                        rx_a_stb_d = !rx_sel_q;
                        rx_b_stb_d = rx_sel_q;
                        rx_data_d  = i_pp_data;
                    end
                endcase
            end
        end else begin
            rx_a_stb_d = 1'b0;
            rx_b_stb_d = 1'b0;
        end
    end

    // RX demux state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_sel_q <= 1'b0;
            rx_esc_q <= 1'b0;
        end else begin
            rx_sel_q <= rx_sel_d;
            rx_esc_q <= rx_esc_d;
        end
    end
`else
    // RX pass-through: every received byte goes to A unmodified.
    always_comb begin
        rx_a_stb_d = i_pp_stb;
        rx_b_stb_d = 1'b0;
        rx_data_d  = i_pp_data;
    end
`endif

    // RX output registers (one-cycle latency from i_pp_stb).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_a_stb_q <= 1'b0;
            rx_b_stb_q <= 1'b0;
            rx_data_q  <= 7'h00;
        end else begin
            rx_a_stb_q <= rx_a_stb_d;
            rx_b_stb_q <= rx_b_stb_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign o_a_rx_stb = rx_a_stb_q;
    assign o_b_rx_stb = rx_b_stb_q;
    assign o_rx_data  = rx_data_q;

endmodule

// File: tb/tb_pportmux.sv
// tb_pportmux: self-checking bench for pportmux (LGBURST = 2).
// A negedge monitor holds a transaction-level model (who may be served, what
// bytes the wire must carry); directed sequences and RX vector tables cover
// the documented scenarios. Honours PPMUX_RXDEMUX_EN for RX expectations.
module tb_pportmux;

    localparam int LGB   = 2;
    localparam int BURST = 1 << LGB;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       i_a_stb   = 1'b0;
    logic [6:0] i_a_data  = 7'h00;
    logic       i_b_stb   = 1'b0;
    logic [6:0] i_b_data  = 7'h00;
    logic       i_pp_busy = 1'b0;
    logic       i_pp_stb  = 1'b0;
    logic [6:0] i_pp_data = 7'h00;
    logic       o_a_busy, o_b_busy, o_pp_stb, o_a_rx_stb, o_b_rx_stb;
    logic [6:0] o_pp_data, o_rx_data;

    pportmux #(.LGBURST(LGB)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_a_stb(i_a_stb), .i_a_data(i_a_data), .o_a_busy(o_a_busy),
        .i_b_stb(i_b_stb), .i_b_data(i_b_data), .o_b_busy(o_b_busy),
        .o_pp_stb(o_pp_stb), .o_pp_data(o_pp_data), .i_pp_busy(i_pp_busy),
        .i_pp_stb(i_pp_stb), .i_pp_data(i_pp_data),
        .o_a_rx_stb(o_a_rx_stb), .o_b_rx_stb(o_b_rx_stb), .o_rx_data(o_rx_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       stb;
        logic [6:0] din;
        logic       ea;
        logic       eb;
        logic [6:0] ed;
    } rx_vec_t;

    int checks = 0;
    int errors = 0;

    logic [6:0] exp_wire[$];
    logic [6:0] wire_seen[$];
    logic [6:0] dir_exp[$];
    rx_vec_t    rx_tbl[$];

    bit         m_owner_b = 1'b0;
    bit         m_selv    = 1'b0;
    int         m_run     = 0;
    bit         prev_hold = 1'b0;
    logic [6:0] prev_data = 7'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic rx_vec_t mkv(input logic stb, input logic [6:0] din,
                                    input logic ea, input logic eb, input logic [6:0] ed);
        rx_vec_t v;
        v.stb = stb; v.din = din; v.ea = ea; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    function automatic logic [6:0] rnd_byte();
        if ($urandom_range(0, 3) == 0) return 7'h7c + 7'($urandom_range(0, 3));
        else return 7'($urandom_range(0, 127));
    endfunction

    // Reference model: what one accepted byte must produce on the wire.
    task automatic model_accept(input bit is_b, input logic [6:0] d);
        if (is_b == m_owner_b && m_run < BURST) m_run++;
        else m_run = 1;
        if (!m_selv || is_b != m_owner_b) exp_wire.push_back(is_b ? 7'h7f : 7'h7e);
        m_owner_b = is_b;
        m_selv    = 1'b1;
        if (d >= 7'h7d) begin
            exp_wire.push_back(7'h7d);
            exp_wire.push_back(d ^ 7'h20);
        end else begin
            exp_wire.push_back(d);
        end
    endtask

    // Negedge monitor: arbitration/busy prediction, wire scoreboard, hold check.
    always @(negedge clk) begin : monitor
        bit own_req, oth_req, any, win_b;
        logic [6:0] w;
        if (rst) begin
            check("rst_busy_a", o_a_busy, 1);
            check("rst_busy_b", o_b_busy, 1);
            exp_wire.delete();
            m_owner_b = 1'b0; m_selv = 1'b0; m_run = 0; prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_stb", o_pp_stb, 1);
                check("hold_data", o_pp_data, prev_data);
            end
            prev_hold = o_pp_stb && i_pp_busy;
            prev_data = o_pp_data;
            any = 1'b0; win_b = 1'b0;
            if (exp_wire.size() == 0) begin
                own_req = m_owner_b ? i_b_stb : i_a_stb;
                oth_req = m_owner_b ? i_a_stb : i_b_stb;
                if (own_req && m_run < BURST) begin any = 1'b1; win_b = m_owner_b; end
                else if (oth_req) begin any = 1'b1; win_b = !m_owner_b; end
                else if (own_req) begin any = 1'b1; win_b = m_owner_b; end
            end
            check("busy_a", o_a_busy, !(any && !win_b));
            check("busy_b", o_b_busy, !(any && win_b));
            if (o_pp_stb && !i_pp_busy) begin
                wire_seen.push_back(o_pp_data);
                if (exp_wire.size() == 0) begin
                    check("wire_unexpected", o_pp_stb, 0);
                end else begin
                    w = exp_wire.pop_front();
                    check("wire_byte", o_pp_data, w);
                end
            end
            if (i_a_stb && !o_a_busy) model_accept(1'b0, i_a_data);
            if (i_b_stb && !o_b_busy) model_accept(1'b1, i_b_data);
        end
    end

    task automatic do_reset();
        rst = 1'b1; i_a_stb = 1'b0; i_b_stb = 1'b0; i_pp_stb = 1'b0; i_pp_busy = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        wire_seen.delete();
        dir_exp.delete();
        check("rst_pp_stb", o_pp_stb, 0);
        check("rst_pp_data", o_pp_data, 7'h00);
        check("rst_a_rx_stb", o_a_rx_stb, 0);
        check("rst_b_rx_stb", o_b_rx_stb, 0);
        check("rst_rx_data", o_rx_data, 7'h00);
    endtask

    task automatic send(input bit is_b, input logic [6:0] d);
        bit ok;
        ok = 1'b0;
        if (is_b) begin i_b_stb = 1'b1; i_b_data = d; end
        else begin i_a_stb = 1'b1; i_a_data = d; end
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            ok = is_b ? !o_b_busy : !o_a_busy;
            cyc();
        end
        i_a_stb = 1'b0;
        i_b_stb = 1'b0;
        if (!ok) fail_now("send");
        else check("tx_latency", o_pp_stb, 1);
    endtask

    task automatic drain();
        for (int c = 0; c < 300; c++) begin
            if (exp_wire.size() == 0 && o_pp_stb == 1'b0) break;
            cyc();
        end
        check("drain_left", exp_wire.size(), 0);
        check("drain_stb", o_pp_stb, 0);
    endtask

    task automatic check_wire(input string name);
        check({name, "_len"}, wire_seen.size(), dir_exp.size());
        for (int i = 0; i < dir_exp.size() && i < wire_seen.size(); i++)
            check(name, wire_seen[i], dir_exp[i]);
        wire_seen.delete();
        dir_exp.delete();
    endtask

    task automatic apply_rx(input rx_vec_t v, input string name);
        logic ea, eb;
        logic [6:0] ed;
`ifdef PPMUX_RXDEMUX_EN
        ea = v.ea; eb = v.eb; ed = v.ed;
`else
        ea = v.stb; eb = 1'b0; ed = v.din;
`endif
        i_pp_stb  = v.stb;
        i_pp_data = v.din;
        cyc();
        check({name, "_a_stb"}, o_a_rx_stb, ea);
        check({name, "_b_stb"}, o_b_rx_stb, eb);
        if (ea || eb) check({name, "_data"}, o_rx_data, ed);
    endtask

    task automatic run_rx_tbl(input string name);
        foreach (rx_tbl[i]) apply_rx(rx_tbl[i], name);
        apply_rx(mkv(1'b0, 7'h00, 1'b0, 1'b0, 7'h00), {name, "_tail"});
        rx_tbl.delete();
    endtask

    initial begin : main
        bit aa, bb, cur_b, tgt;
        bit who[$];
        logic [6:0] a_v, b_v, p;
        do_reset();

        // Single A byte after reset: SEL_A then the byte.
        send(1'b0, 7'h41);
        drain();
        dir_exp = {7'h7e, 7'h41};
        check_wire("one_a");

        // Same-owner bytes need no SEL; switching owner inserts SEL_B.
        do_reset();
        send(1'b0, 7'h41);
        send(1'b0, 7'h42);
        send(1'b1, 7'h30);
        drain();
        dir_exp = {7'h7e, 7'h41, 7'h42, 7'h7f, 7'h30};
        check_wire("a_a_b");

        // Reserved byte from B is escaped; the wire bytes decode back to B:7e.
        do_reset();
        send(1'b1, 7'h7e);
        drain();
        dir_exp = {7'h7f, 7'h7d, 7'h5e};
        check_wire("b_esc");
        rx_tbl = {mkv(1'b1, 7'h7f, 1'b0, 1'b0, 7'h00),
                  mkv(1'b1, 7'h7d, 1'b0, 1'b0, 7'h00),
                  mkv(1'b1, 7'h5e, 1'b0, 1'b1, 7'h7e)};
        run_rx_tbl("rx_b_esc");

        // Both stream continuously: bursts of BURST bytes alternate.
        do_reset();
        a_v = 7'h10; b_v = 7'h50;
        i_a_stb = 1'b1; i_a_data = a_v; i_b_stb = 1'b1; i_b_data = b_v;
        for (int c = 0; c < 400 && who.size() < 24; c++) begin
            @(negedge clk);
            aa = !o_a_busy; bb = !o_b_busy;
            cyc();
            if (aa) begin who.push_back(1'b0); a_v = a_v + 7'd1; i_a_data = a_v; end
            if (bb) begin who.push_back(1'b1); b_v = b_v + 7'd1; i_b_data = b_v; end
        end
        i_a_stb = 1'b0; i_b_stb = 1'b0;
        if (who.size() < 24) fail_now("stream");
        foreach (who[k]) check("stream_owner", who[k], (k / BURST) % 2);
        drain();

        // Port stalled during SEL, then reset mid-transfer.
        do_reset();
        i_pp_busy = 1'b1;
        send(1'b0, 7'h41);
        for (int c = 0; c < 10; c++) begin
            check("stall_stb", o_pp_stb, 1);
            check("stall_data", o_pp_data, 7'h7e);
            cyc();
        end
        rst = 1'b1;
        cyc();
        check("after_rst_stb", o_pp_stb, 0);
        rst = 1'b0; i_pp_busy = 1'b0;
        wire_seen.delete();
        send(1'b0, 7'h43);
        drain();
        dir_exp = {7'h7e, 7'h43};
        check_wire("after_rst");

        // RX directed stream (rx_sel starts at A after reset).
        do_reset();
        rx_tbl = {mkv(1'b1, 7'h41, 1'b1, 1'b0, 7'h41),
                  mkv(1'b1, 7'h7f, 1'b0, 1'b0, 7'h00),
                  mkv(1'b1, 7'h31, 1'b0, 1'b1, 7'h31),
                  mkv(1'b1, 7'h7d, 1'b0, 1'b0, 7'h00),
                  mkv(1'b1, 7'h5d, 1'b0, 1'b1, 7'h7d),
                  mkv(1'b1, 7'h7e, 1'b0, 1'b0, 7'h00),
                  mkv(1'b1, 7'h42, 1'b1, 1'b0, 7'h42)};
        run_rx_tbl("rx_dir");

        // RX random: messages encoded with SEL/ESC, random gaps.
        do_reset();
        cur_b = 1'b0;
        for (int m = 0; m < 150; m++) begin
            tgt = 1'($urandom_range(0, 1));
            p   = rnd_byte();
            if (tgt != cur_b || $urandom_range(0, 7) == 0) begin
                rx_tbl.push_back(mkv(1'b1, tgt ? 7'h7f : 7'h7e, 1'b0, 1'b0, 7'h00));
                cur_b = tgt;
            end
            if ($urandom_range(0, 3) == 0)
                rx_tbl.push_back(mkv(1'b0, rnd_byte(), 1'b0, 1'b0, 7'h00));
            if (p >= 7'h7d) begin
                rx_tbl.push_back(mkv(1'b1, 7'h7d, 1'b0, 1'b0, 7'h00));
                if ($urandom_range(0, 3) == 0)
                    rx_tbl.push_back(mkv(1'b0, rnd_byte(), 1'b0, 1'b0, 7'h00));
                rx_tbl.push_back(mkv(1'b1, p ^ 7'h20, !tgt, tgt, p));
            end else begin
                rx_tbl.push_back(mkv(1'b1, p, !tgt, tgt, p));
            end
        end
        run_rx_tbl("rx_rnd");

        // TX random: random requests and port back-pressure vs the monitor model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!i_a_stb && $urandom_range(0, 3) != 0) begin i_a_stb = 1'b1; i_a_data = rnd_byte(); end
            if (!i_b_stb && $urandom_range(0, 3) != 0) begin i_b_stb = 1'b1; i_b_data = rnd_byte(); end
            i_pp_busy = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            aa = i_a_stb && !o_a_busy;
            bb = i_b_stb && !o_b_busy;
            cyc();
            if (aa) i_a_stb = 1'b0;
            if (bb) i_b_stb = 1'b0;
        end
        i_a_stb = 1'b0; i_b_stb = 1'b0; i_pp_busy = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
